traffic_display_driver: RTL
===========================

Name: traffic_display_driver

Overview:
- Downstream consumer of traffic_light_fsm.
- Takes the two 8-bit countdown values (count1, count2) and the two 3-bit light vectors.
- Drives a 4-digit multiplexed, active-low 7-segment display: two digits per direction. Also drives registered lamp outputs.
- Binary-to-BCD conversion is sequential (shift-add-3). The digit scan is prescaled from the system clock.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays enabled; legal range ≥2.
- CLAMP_MAX, 99: saturation value for the displayed count; inputs above it display as CLAMP_MAX.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- count1  input  8  direction-1 remaining time, binary.
- count2  input  8  direction-2 remaining time, binary.
- light1  input  3  direction-1 lamp vector.
- light2  input  3  direction-2 lamp vector.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- an  output  4  digit enables, active-low, one-hot-zero.
- led1  output  3  registered light1.
- led2  output  3  registered light2.
- busy  output  1  conversion in progress.

Behaviour:
- Single clock, clk. Reset is rst: synchronous, active-high. All state is updated only on the rising edge of clk.
- Reset values:
  - seg=7'h7F, an=4'hF, led1=led2=0, busy=0.
  - Converter state IDLE; snapshots and digit registers 0.
  - Prescaler 0; scan index 0.
- Reset mid-conversion aborts the conversion; no commit occurs.
- Lamps: led1/led2 equal light1/light2 delayed by exactly 1 cycle. No decoding.
- Converter FSM, states IDLE, CONV1, CONV2, COMMIT:
  - IDLE: if count1≠snap1 or count2≠snap2 at edge E0, load snap1=count1 and snap2=count2 (both captured on the same edge), set busy=1, go to CONV1.
  - CONV1: 8 cycles (E1..E8). Each cycle applies add-3 to any BCD nibble ≥5, then shifts left 1, on clamp(snap1).
  - CONV2: 8 cycles (E9..E16), same operation on clamp(snap2).
  - COMMIT: at E17, write all four digit registers atomically, clear busy, go to IDLE.
  - Latency: capture to visible digit registers = 17 cycles. busy is high for E0..E16 exclusive of the commit edge, i.e. 17 cycles.
  - Input changes while busy are ignored. On return to IDLE the compare re-fires if the inputs differ from the snapshots. Latest value wins; there is no queueing.
  - Clamp: value>CLAMP_MAX converts as CLAMP_MAX. The BCD width is 8 bits (tens, ones); hundreds are never produced.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. On wrap, scan index increments mod 4.
  - Index mapping: 0 = count1 ones (an=4'b1110); 1 = count1 tens (1101); 2 = count2 ones (1011); 3 = count2 tens (0111).
  - seg and an are registered together, so they are always mutually consistent. They update on the edge following an index change.
- Leading-zero blanking: a tens digit of 0 drives seg=7'h7F while its anode is still enabled. Ones digits are never blanked; 0 displays "0".
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Digits are committed only in COMMIT. The display never shows a half-converted value.

Decomposition:
- Package traffic_pkg:
  - Converter state encoding (2-bit).
  - SEG_BLANK=7'h7F and the SEG_0..SEG_9 constants.
  - AN_DIG0..AN_DIG3 constants.
- Sub-module bin_to_bcd8: a sequential 8-bit shift-add-3 converter with start/done. It is instantiated once and reused for count1 then count2 under FSM control.

Test Plan (SCAN_DIV=4):
- Reset: rst high 2 cycles → seg=7F, an=F, busy=0. After release with counts 0: an cycles E,D,B,7 every 4 clocks; seg=1000000 on E and B, 7F on D and 7.
- count1=45, count2=7 → busy high 17 cycles, then an=E shows 0010010, D shows 0011001, B shows 1111000, 7 shows 7F.
- count1=200, count2=99 → all four digits 0010000 (clamped 99).
- count2=30, then count2=12 five cycles later → first commit shows 3/0, second conversion starts right after; 1/2 is visible by cycle 36 from the first change.
- rst asserted at cycle 8 of CONV1 → the next edge gives busy=0, digit registers 0, seg=7F, an=F; no commit of the in-flight value.
- light1=3'b100, light2=3'b001 → led1=100 and led2=001 exactly 1 cycle later.

Source files
------------

// File: rtl/traffic_display_driver_pkg.sv
// traffic_pkg: shared types and constants for the traffic display driver.
//   conv_state_e     - converter FSM encoding (2-bit)
//   SEG_BLANK/SEG_n  - active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   AN_DIG0..3       - active-low digit enables, one per scan index
//   seg_encode       - BCD digit to segment code
//   an_select        - scan index to anode pattern
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV1  = 2'd1,
        ST_CONV2  = 2'd2,
        ST_COMMIT = 2'd3
    } conv_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam logic [3:0] AN_DIG0 = 4'b1110;  // count1 ones
    localparam logic [3:0] AN_DIG1 = 4'b1101;  // count1 tens
    localparam logic [3:0] AN_DIG2 = 4'b1011;  // count2 ones
    localparam logic [3:0] AN_DIG3 = 4'b0111;  // count2 tens

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] an_select(input logic [1:0] i);
        case (i)
            2'd0:    return AN_DIG0;
            2'd1:    return AN_DIG1;
            2'd2:    return AN_DIG2;
            default: return AN_DIG3;
        endcase
    endfunction

endpackage

// File: rtl/traffic_display_driver_if.sv
// Signal bundle between the traffic controller side and the display driver.
//   count1/count2 - binary countdown values in
//   light1/light2 - lamp vectors in
//   seg/an        - multiplexed active-low 7-segment display out
//   led1/led2     - registered lamp outputs
//   busy          - BCD conversion in progress
// master: the side producing counts/lights; slave: the display driver.
interface traffic_display_driver_if;
    logic [7:0] count1;
    logic [7:0] count2;
    logic [2:0] light1;
    logic [2:0] light2;
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] led1;
    logic [2:0] led2;
    logic       busy;

    modport master (
        output count1, count2, light1, light2,
        input  seg, an, led1, led2, busy
    );

    modport slave (
        input  count1, count2, light1, light2,
        output seg, an, led1, led2, busy
    );
endinterface

// File: rtl/traffic_display_driver_bin_to_bcd8.sv
// bin_to_bcd8: sequential 8-bit shift-add-3 (double dabble) converter.
//   clk, rst - clock, synchronous active-high reset
//   start    - begin conversion of din; the start edge performs step 1
//   din      - binary value, must be <= 99 (only tens/ones are kept)
//   bcd      - {tens, ones}; holds the result once active drops
//   active   - steps 2..8 still pending
//   done     - high in the cycle whose rising edge performs the 8th step
module bin_to_bcd8
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic [7:0] bcd,
    output logic       active,
    output logic       done
);

    logic [7:0] shreg;
    logic [2:0] steps;  // steps already completed

    // One iteration: add 3 to any nibble >= 5, then shift in the next bit.
    // The hundreds carry is dropped; inputs are clamped below 100.
    function automatic logic [7:0] dabble(input logic [7:0] b, input logic bit_in);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = (b[7:4] >= 4'd5) ? b[7:4] + 4'd3 : b[7:4];
        lo = (b[3:0] >= 4'd5) ? b[3:0] + 4'd3 : b[3:0];
        return {hi[2:0], lo, bit_in};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd    <= '0;
            shreg  <= '0;
            steps  <= '0;
            active <= 1'b0;
        end else if (start) begin
            bcd    <= dabble(8'h00, din[7]);
            shreg  <= {din[6:0], 1'b0};
            steps  <= 3'd1;
            active <= 1'b1;
        end else if (active) begin
            bcd   <= dabble(bcd, shreg[7]);
            shreg <= {shreg[6:0], 1'b0};
            steps <= steps + 3'd1;
            if (steps == 3'd7)
                active <= 1'b0;
        end
    end

    assign done = active && (steps == 3'd7);

endmodule

// File: rtl/traffic_display_driver.sv
// traffic_display_driver: BCD-converts two countdown values and scans them
// onto a 4-digit multiplexed active-low 7-segment display; also registers
// the two lamp vectors.
//   clk, rst - clock, synchronous active-high reset
//   bus      - traffic_display_driver_if.slave (counts/lights in,
//              seg/an/led1/led2/busy out)
// One converter is shared: count1 converts first, its result is parked in
// hold1 while count2 converts, then all four digits commit on one edge so
// the display never shows a mix of old and new values.
module traffic_display_driver
    import traffic_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int CLAMP_MAX = 99
) (
    input  logic                      clk,
    input  logic                      rst,
    traffic_display_driver_if.slave   bus
);

    localparam int         PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [7:0] CLAMP     = 8'(CLAMP_MAX);

    conv_state_e     state, state_n;
    logic [7:0]      snap1, snap2, hold1;
    logic [3:0][3:0] digits;       // [3]=c2 tens, [2]=c2 ones, [1]=c1 tens, [0]=c1 ones
    logic [PW-1:0]   presc;
    logic [1:0]      scan_idx;
    logic [6:0]      disp_seg;
    logic [3:0]      disp_an;
    logic [2:0]      lamp1, lamp2;
    logic            changed;
    logic            conv_start, conv_active, conv_done;
    logic [7:0]      conv_din, conv_bcd;

    function automatic logic [7:0] clamp(input logic [7:0] v);
        return (v > CLAMP) ? CLAMP : v;
    endfunction

    assign changed = (bus.count1 != snap1) || (bus.count2 != snap2);

    bin_to_bcd8 u_bcd (
        .clk    (clk),
        .rst    (rst),
        .start  (conv_start),
        .din    (conv_din),
        .bcd    (conv_bcd),
        .active (conv_active),
        .done   (conv_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Start fires on the first cycle of each CONV state; the converter is
    // always idle then because the previous conversion has run to completion.
    always_comb begin
        state_n    = state;
        conv_start = 1'b0;
        conv_din   = clamp(snap1);
        case (state)
            ST_IDLE:   if (changed) state_n = ST_CONV1;
            ST_CONV1: begin
                conv_start = !conv_active;
                if (conv_done) state_n = ST_CONV2;
            end
            ST_CONV2: begin
                conv_start = !conv_active;
                conv_din   = clamp(snap2);
                if (conv_done) state_n = ST_COMMIT;
            end
            ST_COMMIT: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap1  <= '0;
            snap2  <= '0;
            hold1  <= '0;
            digits <= '0;
        end else begin
            if (state == ST_IDLE && changed) begin
                snap1 <= bus.count1;
                snap2 <= bus.count2;
            end
            // count1's result is still on conv_bcd when count2 starts
            if (state == ST_CONV2 && conv_start)
                hold1 <= conv_bcd;
            if (state == ST_COMMIT)
                digits <= {conv_bcd, hold1};
        end
    end

    // Scan prescaler and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            scan_idx <= '0;
        end else if (presc == PRESC_MAX) begin
            presc    <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // seg and an register together; odd indices are tens and blank on zero
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_seg <= SEG_BLANK;
            disp_an  <= 4'hF;
            lamp1    <= '0;
            lamp2    <= '0;
        end else begin
            disp_an  <= an_select(scan_idx);
            disp_seg <= (scan_idx[0] && digits[scan_idx] == 4'd0) ? SEG_BLANK
                                                                   : seg_encode(digits[scan_idx]);
            lamp1    <= bus.light1;
            lamp2    <= bus.light2;
        end
    end

    assign bus.seg  = disp_seg;
    assign bus.an   = disp_an;
    assign bus.led1 = lamp1;
    assign bus.led2 = lamp2;
    assign bus.busy = (state != ST_IDLE);

endmodule
